offchip_sram_bist: RTL
======================

Name: offchip_sram_bist

Overview:
- Synthesizable memory-test initiator that drives the requester side of the memory_blocks_if port of offchip_sram_controller, so it is the opposite end of that interface.
- It writes a selectable pattern across a word range, reads the range back, and compares each word against the expected value.
- It reports pass/fail, the error count, the first failing address, and a wait-timeout flag.
- Used for silicon bring-up of the off-chip SRAM and as a self-checking stimulus source in controller benches.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- NUM_WORDS, 1024, number of words tested; must be ≥1.
- BASE_ADDR, 0, byte address of the first word; word-aligned.
- MAX_WAIT, 255, largest number of consecutive sram_wait-high cycles tolerated within one transaction.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  begin test; sampled in IDLE or DONE only.
- pattern_sel  in  2  0=all ones, 1=all zeros, 2=data equals addr, 3=checkerboard (even word 0xAAAA.., odd word 0x5555..); captured at start.
- wen  out  1  write request.
- ren  out  1  read request.
- addr  out  ADDR_W  byte address.
- wdata  out  DATA_W  write data.
- byte_en  out  DATA_W/8  byte enables.
- sram_rdata  in  DATA_W  read data from the controller.
- sram_wait  in  1  controller busy; the current request is not yet accepted.
- busy  out  1  test in progress.
- done  out  1  test finished; held until next start.
- pass  out  1  valid when done; 1 only if zero errors and no timeout.
- err_count  out  16  number of read mismatches; saturates at 0xFFFF.
- first_err_addr  out  ADDR_W  address of the first mismatch.
- timeout  out  1  test aborted on a wait timeout.

Behaviour:
- Reset values: all outputs 0 and the FSM in IDLE. Reset asserted mid-test aborts immediately; no further requests are issued.
- FSM states: IDLE, WRITE, READ, DONE.
- IDLE/DONE → WRITE when start=1. On that edge:
  - index and wait counter cleared;
  - err_count, first_err_addr, timeout, pass and done cleared;
  - pattern_sel latched.
- start while busy is ignored.
- Request outputs:
  - addr = BASE_ADDR + 4*index.
  - byte_en is all ones while wen or ren is asserted, 0 otherwise.
  - wdata = expected(index), where expected(i) is: all ones (sel 0), zeros (sel 1), the zero-extended/truncated addr (sel 2), or 0xAA.. when i is even and 0x55.. when i is odd (sel 3).
  - wdata is 0 outside WRITE.
- Handshake:
  - A request stays asserted and holds addr, wdata and byte_en stable while sram_wait=1.
  - The request completes on a rising edge where it is asserted and sram_wait=0; sram_rdata is sampled on that same edge.
  - wen and ren are never asserted together.
- WRITE:
  - wen=1 from the first cycle after start.
  - Each completed write increments index.
  - The write of index NUM_WORDS-1 completes → READ with index reset to 0. ren is asserted on the next cycle, with no idle gap.
- READ:
  - ren=1. On each completed read, compare sram_rdata against expected(index).
  - On a mismatch, err_count increments (saturating). If it was 0, first_err_addr takes addr.
  - The read of index NUM_WORDS-1 completes → DONE.
- Zero-wait latency: start edge → 2*NUM_WORDS cycles of requests → done=1 on the following cycle.
- Timeout:
  - The wait counter clears on every completed transaction and increments on each cycle with sram_wait=1.
  - On the MAX_WAIT+1-th consecutive wait cycle the block goes to DONE with timeout=1 and pass=0; the request deasserts on the next cycle.
- DONE: busy=0, done=1, pass = (err_count==0 && !timeout). Errors and timeout are held.
- busy=1 in WRITE and READ only.
- Index wrap: index never exceeds NUM_WORDS-1; no address wrap beyond the range.

Test Plan:
- Zero-wait, sel 0, NUM_WORDS=16, ideal memory model → 16 wen cycles at 0x00..0x3C, 16 ren cycles, done at cycle 33, pass=1, err_count=0.
- sram_wait high for 3 cycles on every request, sel 3 → addr/wdata stable during waits, word1 wdata=0x55555555, pass=1, total 128 request cycles.
- Model with bit 0 of the word at 0x20 stuck at 0, sel 0 → err_count=1, first_err_addr=0x20, pass=0.
- sram_wait held high on the 5th write, MAX_WAIT=7 → timeout=1 after 8 wait cycles, done=1, pass=0, wen low on the next cycle.
- RST asserted during READ, then start with sel 2 → all outputs 0 while reset; the rerun passes with wdata==addr.
- start pulsed while busy → ignored; the run completes with unchanged count; a second start from DONE clears done and err_count.

Source files
------------

// File: rtl/offchip_sram_bist.sv
// offchip_sram_bist: memory-test initiator for the requester side of the
// off-chip SRAM controller port. It writes a pattern over a word range, reads
// it back and compares each word. It reports pass/fail, the error count, the
// first failing address and a wait timeout.
module offchip_sram_bist #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 1024,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WAIT  = 255
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [1:0]          pattern_sel,
    output logic                wen,
    output logic                ren,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] byte_en,
    input  logic [DATA_W-1:0]   sram_rdata,
    input  logic                sram_wait,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic                timeout
);

    localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [IDX_W-1:0]  idx;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        pat;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] expected;
    logic              req;
    logic              last;

    assign wen     = (state == S_WRITE);
    assign ren     = (state == S_READ);
    assign req     = wen | ren;
    assign busy    = req;
    assign done    = (state == S_DONE);
    assign pass    = done && (err_count == 16'd0) && !timeout;
    assign last    = (idx == IDX_W'(NUM_WORDS - 1));

    // Request address is only driven while a request is up, so idle outputs are 0.
    assign cur_addr = ADDR_W'(BASE_ADDR) + (ADDR_W'(idx) << 2);
    assign addr     = req ? cur_addr : '0;
    assign byte_en  = req ? '1 : '0;
    assign wdata    = wen ? expected : '0;

    // Pattern generator: the expected word for the current index.
    always_comb begin
        expected = '0;
        case (pat)
            2'd0:    expected = '1;
            2'd1:    expected = '0;
            2'd2:    expected = DATA_W'(cur_addr);
            default: expected = idx[0] ? {DATA_W/8{8'h55}} : {DATA_W/8{8'hAA}};
        endcase
    end

    // Test sequencer: write pass, read/compare pass, wait timeout and result capture.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= S_IDLE;
            idx            <= '0;
            wait_cnt       <= '0;
            pat            <= 2'd0;
            err_count      <= 16'd0;
            first_err_addr <= '0;
            timeout        <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state          <= S_WRITE;
                        idx            <= '0;
                        wait_cnt       <= '0;
                        pat            <= pattern_sel;
                        err_count      <= 16'd0;
                        first_err_addr <= '0;
                        timeout        <= 1'b0;
                    end
                end
                default: begin
                    if (sram_wait) begin
                        // The MAX_WAIT+1-th consecutive wait cycle aborts the test.
                        if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
                            state   <= S_DONE;
                            timeout <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else begin
                        wait_cnt <= '0;
                        if (ren && (sram_rdata != expected)) begin
                            if (err_count != 16'hFFFF)
                                err_count <= err_count + 16'd1;
                            if (err_count == 16'd0)
                                first_err_addr <= cur_addr;
                        end
                        if (last) begin
                            idx   <= '0;
                            state <= wen ? S_READ : S_DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
